if_prefetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the byte-addressed, big-endian instruction ROM.
- Owns the fetch PC and drives the ROM's active-low read enable and byte address.
- Captures each returned 32-bit word into a small FIFO and presents {pc, instruction} to decode through a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the queue and reloads the fetch PC.

---
 rtl/if_prefetch_queue.sv | 140 ++++++++++++++
 tb/tb_if_prefetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch stage sitting directly in front of a byte-addressed,
// big-endian instruction ROM. It owns the fetch PC, drives the ROM read
// strobe and address, captures each returned word into a small FIFO and
// presents {pc, instruction} pairs to decode over a valid/ready handshake.
// A redirect flushes the FIFO and reloads the fetch PC (word aligned).
//
// Ports:
//   CLK             rising-edge clock
//   nRST            asynchronous active-low reset
//   rom_nRD         ROM read enable, active low (high whenever no fetch)
//   rom_addr        ROM byte address, always equal to the fetch PC
//   rom_data        ROM word, combinational from rom_addr
//   redirect_valid  flush the queue and reload the fetch PC this cycle
//   redirect_pc     new fetch PC (low two bits ignored)
//   out_valid       head entry is valid
//   out_ready       decode accepts the head entry
//   out_pc          PC of the head entry (0 when empty)
//   out_inst        instruction of the head entry (0 when empty)
//   fetch_end       fetch PC has run past the ROM end; fetching halted
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 100
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        rom_nRD,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        fetch_end
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [32:0]   ROM_LIMIT  = 33'(ROM_BYTES);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fetch_pc;

    logic            in_range;
    logic            pop;
    logic            fetch;

    // -------------------------------------------------------------------------
    // Fetch decision
    // -------------------------------------------------------------------------
    // in_range is evaluated in 33 bits so a PC near 0xFFFF_FFFC cannot wrap
    // around and look like a small, legal address.
    // A full queue may still fetch when the head leaves on the same edge,
    // which is what sustains one instruction per cycle.
    // nRST appears here directly so the ROM strobe drops the instant reset
    // asserts, without waiting for a clock.
    // NOTE: every signal driven in an always_comb gets a value on every path
    // (here trivially, as plain assignments); a missing branch infers a latch.
    always_comb begin
        in_range = (({1'b0, fetch_pc} + 33'd4) <= ROM_LIMIT);
        pop      = (count != '0) & out_ready;
        fetch    = nRST & ~redirect_valid & in_range & ((count != COUNT_FULL) | pop);
    end

    assign rom_addr  = fetch_pc;
    assign rom_nRD   = ~fetch;
    assign fetch_end = ~in_range;

    // -------------------------------------------------------------------------
    // Control state: pointers, occupancy and fetch PC
    // -------------------------------------------------------------------------
    // Redirect wins over everything: a pop accepted by decode in the redirect
    // cycle is simply discarded along with the rest of the queue.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (fetch) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fetch, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, because out_valid is derived from count.
    // fetch already includes nRST, so no write can happen during reset.
    always_ff @(posedge CLK) begin
        if (fetch) begin
            mem[wr_ptr] <= '{pc: fetch_pc, inst: rom_data};
        end
    end

    // -------------------------------------------------------------------------
    // Output: head of queue, forced to zero when empty
    // -------------------------------------------------------------------------
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc   : 32'h0;
    assign out_inst  = out_valid ? head.inst : 32'h0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_queue
//
// Self-checking bench for if_prefetch_queue. A byte-array ROM feeds the DUT
// combinationally; a queue-based reference model tracks what decode should
// see and which address the fetch stage should present each cycle.
// Directed phases follow the intended use cases, then a randomized phase
// mixes redirects, back-pressure and out-of-range targets.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned ROM_BYTES = 100;

    logic        CLK;
    logic        nRST;
    logic        rom_nRD;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        fetch_end;

    if_prefetch_queue #(
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .ROM_BYTES (ROM_BYTES)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .rom_nRD        (rom_nRD),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .fetch_end      (fetch_end)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Big-endian byte ROM: byte at the word address lands in bits [31:24].
    logic [7:0] rom [ROM_BYTES];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (({1'b0, a} + 33'd4) <= 33'(ROM_BYTES))
            return {rom[a], rom[a + 1], rom[a + 2], rom[a + 3]};
        return 32'h0;
    endfunction

    assign rom_data = rom_word(rom_addr);

    // Reference model: the queue as decode sees it, plus the fetch PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the
    // model on the rising edge. Entered and left just after a rising edge.
    task automatic cycle(input logic rv, input logic [31:0] rp, input logic rdy);
        logic in_r;
        logic exp_pop;
        logic exp_fetch;
        ent_t e;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        @(negedge CLK);
        in_r      = (({1'b0, m_pc} + 33'd4) <= 33'(ROM_BYTES));
        exp_pop   = (q.size() != 0) && rdy;
        exp_fetch = !rv && in_r && ((q.size() < DEPTH) || exp_pop);
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check("out_pc",    out_pc,   (q.size() != 0) ? q[0].pc   : 32'h0);
        check("out_inst",  out_inst, (q.size() != 0) ? q[0].inst : 32'h0);
        check("rom_nRD",   {31'b0, rom_nRD},   {31'b0, !exp_fetch});
        check("rom_addr",  rom_addr, m_pc);
        check("fetch_end", {31'b0, fetch_end}, {31'b0, !in_r});
        @(posedge CLK);
        if (rv) begin
            q.delete();
            m_pc = rp & 32'hFFFF_FFFC;
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_fetch) begin
                e.pc   = m_pc;
                e.inst = rom_word(m_pc);
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy);
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic async_reset_pulse();
        nRST = 1'b0;
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_rom_nRD",   {31'b0, rom_nRD},   32'h1);
        check("rst_out_pc",    out_pc,   32'h0);
        check("rst_rom_addr",  rom_addr, RESET_PC);
        nRST = 1'b1;
        q.delete();
        m_pc = RESET_PC;
    endtask

    initial begin
        nRST           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'($urandom);
        {rom[0], rom[1], rom[2],  rom[3]}  = 32'h8C01_0000;
        {rom[4], rom[5], rom[6],  rom[7]}  = 32'h0022_1820;
        {rom[8], rom[9], rom[10], rom[11]} = 32'h0800_0000;
        q.delete();
        m_pc = RESET_PC;

        // Values held during reset.
        #2;
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_out_pc",    out_pc,   32'h0);
        check("reset_out_inst",  out_inst, 32'h0);
        check("reset_fetch_end", {31'b0, fetch_end}, 32'h0);
        check("reset_rom_nRD",   {31'b0, rom_nRD},   32'h1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Free run from reset: pc 0,4,8 stream out back to back.
        run(6, 1'b1);

        // Back-pressure: fill to DEPTH and stall, then drain with push+pop.
        run(10, 1'b0);
        run(4, 1'b1);

        // Redirect with a full queue, unaligned target.
        run(5, 1'b0);
        cycle(1'b1, 32'h0000_002E, 1'b0);
        run(2, 1'b0);
        run(3, 1'b1);

        // End of ROM: only 92 and 96 are fetched, then drain.
        cycle(1'b1, 32'd92, 1'b0);
        run(4, 1'b0);
        run(4, 1'b1);

        // Asynchronous reset with three entries queued.
        cycle(1'b1, 32'h0, 1'b0);
        run(3, 1'b0);
        async_reset_pulse();
        run(4, 1'b1);

        // Redirect and pop in the same cycle with two entries queued.
        cycle(1'b1, 32'h0, 1'b0);
        run(2, 1'b0);
        cycle(1'b1, 32'h0000_0010, 1'b1);
        run(5, 1'b1);

        // Randomized mix, including wrap-region and past-end targets.
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rp;
            logic        rdy;
            rv  = ($urandom_range(0, 15) == 0);
            rp  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                              : 32'($urandom_range(0, 120));
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, rp, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
